// File: rtl/regfile_banked.sv
// Parametrised register file: NUM_RD async read ports, one byte-lane write port, post-reset clear sweep.
// Optional macro REGFILE_BYPASS_EN: same-cycle write-to-read forwarding on every read port.
module regfile_banked #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [DATA_W/8-1:0]      wr_be,
  output logic                     init_busy,
  output logic                     dbg_state
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int NB    = DATA_W / 8;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]   w_cnt_next;
  logic                w_clr_we;
  logic                w_wr_ok;
  logic                w_fwd;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_clr_we     = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_clr_we   = rst_n;
        w_cnt_next = r_cnt + 1'b1;
        if (r_cnt == '1) w_state_next = ST_RUN;
      end
      ST_RUN: begin
        w_state_next = ST_RUN;
      end
      default: w_state_next = ST_CLEAR;
    endcase
  end

  // Storage has no reset; the edge on which rst_n is low leaves it untouched.
  assign w_fwd   = wr_en && (wr_addr != '0) && (r_state == ST_RUN);
  assign w_wr_ok = rst_n && w_fwd;

  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr_ok) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) r_mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic [DATA_W-1:0] w_merged;
  always_comb begin
    w_merged = r_mem[wr_addr];
    for (int i = 0; i < NB; i++) begin
      if (wr_be[i]) w_merged[8*i +: 8] = wr_data[8*i +: 8];
    end
  end
`endif

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic [DATA_W-1:0] w_rv;
    assign w_ra = rd_addr[k*ADDR_W +: ADDR_W];
    always_comb begin
      w_rv = r_mem[w_ra];
`ifdef REGFILE_BYPASS_EN
      if (w_fwd && (w_ra == wr_addr)) w_rv = w_merged;
`endif
      // Entry 0 is architecturally zero even though its storage exists.
      if (init_busy || (w_ra == '0)) w_rv = '0;
    end
    assign rd_data[k*DATA_W +: DATA_W] = w_rv;
  end

  assign init_busy = (r_state == ST_CLEAR);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_regfile_banked.sv
// Directed bench for regfile_banked: default instance (32x32, 2 ports) and a 8x64, 3-port instance.
module tb_regfile_banked;

  logic         clk;
  logic         rst_n;
  int           errors;
  int           checks;

  // Default-parameter instance
  logic [9:0]   rd_addr0;
  logic [63:0]  rd_data0;
  logic         wr_en0;
  logic [4:0]   wr_addr0;
  logic [31:0]  wr_data0;
  logic [3:0]   wr_be0;
  logic         busy0;
  logic         dbg0;

  // 64-bit, 8-entry, 3-port instance
  logic [8:0]   rd_addr1;
  logic [191:0] rd_data1;
  logic         wr_en1;
  logic [2:0]   wr_addr1;
  logic [63:0]  wr_data1;
  logic [7:0]   wr_be1;
  logic         busy1;
  logic         dbg1;

  regfile_banked u_dut0 (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr0), .rd_data(rd_data0),
    .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0), .wr_be(wr_be0),
    .init_busy(busy0), .dbg_state(dbg0)
  );

  regfile_banked #(.DATA_W(64), .ADDR_W(3), .NUM_RD(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr1), .rd_data(rd_data1),
    .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1), .wr_be(wr_be1),
    .init_busy(busy1), .dbg_state(dbg1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr0(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en0 = 1'b1; wr_addr0 = a; wr_data0 = d; wr_be0 = be;
    step();
    wr_en0 = 1'b0;
  endtask

  // Releases reset and returns how many cycles each instance stayed busy.
  task automatic release_and_count(output int n0, output int n1);
    rst_n = 1'b1;
    n0 = 0;
    n1 = 0;
    while (busy0 && n0 < 100) begin
      if (busy1) n1++;
      step();
      n0++;
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 32; i++) begin
      rd_addr0 = {5'(31 - i), 5'(i)};
      #1;
      chk({tag, "_p0"}, {32'h0, rd_data0[31:0]}, 64'h0);
      chk({tag, "_p1"}, {32'h0, rd_data0[63:32]}, 64'h0);
    end
  endtask

  logic [63:0] exp_hz;
  int          n0;
  int          n1;

  initial begin
    errors = 0; checks = 0;
    rst_n = 1'b0;
    rd_addr0 = '0; wr_en0 = 1'b0; wr_addr0 = '0; wr_data0 = '0; wr_be0 = '0;
    rd_addr1 = '0; wr_en1 = 1'b0; wr_addr1 = '0; wr_data1 = '0; wr_be1 = '0;

    // Reset held for 3 cycles
    repeat (3) step();
    chk("reset_busy0", 64'(busy0), 64'h1);
    chk("reset_busy1", 64'(busy1), 64'h1);
    rd_addr0 = {5'd4, 5'd3};
    #1;
    chk("reset_rd_forced0", rd_data0, 64'h0);

    // Write attempts during the sweep must be ignored
    wr_en0 = 1'b1; wr_addr0 = 5'd3; wr_data0 = 32'hFFFF_FFFF; wr_be0 = 4'hF;
    release_and_count(n0, n1);
    wr_en0 = 1'b0;
    chk("clear_len32", 64'(n0), 64'd32);
    chk("clear_len8", 64'(n1), 64'd8);
    chk("run_busy0", 64'(busy0), 64'h0);
    chk("run_state0", 64'(dbg0), 64'h1);
    check_all_zero("post_clear");

    // Full write, then a write to entry 0
    wr0(5'd5, 32'hDEAD_BEEF, 4'hF);
    rd_addr0 = {5'd0, 5'd5};
    #1;
    chk("full_wr", {32'h0, rd_data0[31:0]}, 64'hDEAD_BEEF);
    wr0(5'd0, 32'hFFFF_FFFF, 4'hF);
    rd_addr0 = {5'd0, 5'd0};
    #1;
    chk("addr0_p0", {32'h0, rd_data0[31:0]}, 64'h0);
    chk("addr0_p1", {32'h0, rd_data0[63:32]}, 64'h0);

    // Byte lanes
    wr0(5'd7, 32'h1122_3344, 4'hF);
    wr0(5'd7, 32'hAABB_CCDD, 4'b0101);
    rd_addr0 = {5'd7, 5'd7};
    #1;
    chk("lanes_0101", {32'h0, rd_data0[31:0]}, 64'h11BB_33DD);
    wr0(5'd7, 32'hFFFF_FFFF, 4'b0000);
    #1;
    chk("lanes_none", {32'h0, rd_data0[63:32]}, 64'h11BB_33DD);

    // Same-cycle read/write of one address
    wr0(5'd9, 32'h1, 4'hF);
`ifdef REGFILE_BYPASS_EN
    exp_hz = 64'h2;
`else
    exp_hz = 64'h1;
`endif
    wr_en0 = 1'b1; wr_addr0 = 5'd9; wr_data0 = 32'h2; wr_be0 = 4'hF;
    rd_addr0 = {5'd9, 5'd9};
    #1;
    chk("hazard_p0", {32'h0, rd_data0[31:0]}, exp_hz);
    chk("hazard_p1", {32'h0, rd_data0[63:32]}, exp_hz);
    step();
    wr_en0 = 1'b0;
    #1;
    chk("hazard_next_p0", {32'h0, rd_data0[31:0]}, 64'h2);
    chk("hazard_next_p1", {32'h0, rd_data0[63:32]}, 64'h2);

    // Wide instance: top lane only on entry 2
    wr_en1 = 1'b1; wr_addr1 = 3'd2; wr_data1 = 64'hFF00_0000_0000_0000; wr_be1 = 8'h80;
    step();
    wr_en1 = 1'b0;
    rd_addr1 = {3'd2, 3'd2, 3'd2};
    #1;
    chk("wide_p0", rd_data1[63:0], 64'hFF00_0000_0000_0000);
    chk("wide_p1", rd_data1[127:64], 64'hFF00_0000_0000_0000);
    chk("wide_p2", rd_data1[191:128], 64'hFF00_0000_0000_0000);

    // Reset with the sweep counter at 10
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (10) step();
    chk("midclr_busy", 64'(busy0), 64'h1);
    rst_n = 1'b0;
    step();
    chk("midclr_rst_busy", 64'(busy0), 64'h1);
    wr_en0 = 1'b1; wr_addr0 = 5'd20; wr_data0 = 32'h1234_5678; wr_be0 = 4'hF;
    release_and_count(n0, n1);
    wr_en0 = 1'b0;
    chk("midclr_len32", 64'(n0), 64'd32);
    check_all_zero("post_midclr");
    #1;
    chk("wide_recleared", rd_data1[63:0], 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
